// File: rtl/demux_dispatcher.sv
// demux_dispatcher: steers a single valid/ready input stream onto one of 8 consumer channels
// through a 3-to-8 demultiplexer.
//
// Channel selection modes:
//   - Round-robin over the enabled channels.
//   - Addressed, using the per-word destination.
//
// A word is held in a register and presented on channel sel until that consumer takes it.
// If the consumer stalls for TIMEOUT cycles, or its channel is disabled, the word is either
// retargeted to another channel or dropped.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   mode              0 = round-robin, 1 = addressed (latched at word acceptance)
//   chan_enable[7:0]  per-channel enable mask
//   in_valid/in_ready input handshake; in_data word, in_dest destination channel
//   sel[2:0]          registered demux select
//   out_valid[7:0]    one-hot valid toward channel sel (or zero)
//   out_data          held word, shared by all channels
//   out_ready[7:0]    per-channel ready
//   sent              one-cycle pulse after a completed delivery
//   drop_cnt[7:0]     saturating count of dropped words
module demux_dispatcher #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic [7:0]            chan_enable,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [2:0]            in_dest,
  output logic [2:0]            sel,
  output logic [7:0]            out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic [7:0]            out_ready,
  output logic                  sent,
  output logic [7:0]            drop_cnt
);

  typedef enum logic [0:0] {StIdle, StDeliver} state_e;

  // The timeout fires in the cycle where the wait counter would reach TIMEOUT, so a stalled
  // channel is presented for exactly TIMEOUT cycles before retarget/drop.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [2:0]            sel_q, sel_d;
  logic [7:0]            out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  sent_q, sent_d;
  logic [7:0]            drop_cnt_q, drop_cnt_d;
  logic [2:0]            rr_ptr_q, rr_ptr_d;
  logic [7:0]            wait_q, wait_d;
  logic                  mode_q, mode_d;
  logic                  drop;
  logic [3:0]            rr_hit;   // {found, index}
  logic [3:0]            alt_hit;  // {found, index}, current sel excluded

  // First set bit of mask, scanning start, start+1, ... modulo 8.
  function automatic logic [3:0] scan(input logic [7:0] mask, input logic [2:0] start);
    logic       found;
    logic [2:0] idx;
    logic [2:0] cand;
    found = 1'b0;
    idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      cand = start + 3'(i);
      if (!found && mask[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    sent_d      = 1'b0;
    drop_cnt_d  = drop_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    wait_d      = wait_q;
    mode_d      = mode_q;
    drop        = 1'b0;
    in_ready    = 1'b0;
    rr_hit      = scan(chan_enable, rr_ptr_q);
    alt_hit     = scan(chan_enable & ~(8'h01 << sel_q), sel_q + 3'd1);

    unique case (state_q)
      StIdle: begin
        // rr_hit[3] is simply |chan_enable.
        in_ready = mode ? 1'b1 : rr_hit[3];
        if (in_valid && in_ready) begin
          out_data_d = in_data;
          mode_d     = mode;
          wait_d     = 8'd0;
          if (mode) begin
            if (chan_enable[in_dest]) begin
              sel_d       = in_dest;
              out_valid_d = 8'h01 << in_dest;
              state_d     = StDeliver;
            end else begin
              drop = 1'b1;
            end
          end else begin
            sel_d       = rr_hit[2:0];
            out_valid_d = 8'h01 << rr_hit[2:0];
            state_d     = StDeliver;
          end
        end
      end

      StDeliver: begin
        // Delivery takes priority over timeout and disable in the same cycle.
        if (out_ready[sel_q]) begin
          out_valid_d = 8'h00;
          sent_d      = 1'b1;
          state_d     = StIdle;
          if (!mode_q) rr_ptr_d = sel_q + 3'd1;
        end else if (wait_q == TimeoutLast || !chan_enable[sel_q]) begin
          wait_d = 8'd0;
          if (mode_q) begin
            drop = 1'b1;
          end else if (alt_hit[3]) begin
            sel_d       = alt_hit[2:0];
            out_valid_d = 8'h01 << alt_hit[2:0];
          end else if (!chan_enable[sel_q]) begin
            drop = 1'b1;
          end
          // Otherwise sel is the only enabled channel: keep waiting on it.
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      default: state_d = StIdle;
    endcase

    if (drop) begin
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
      out_valid_d = 8'h00;
      state_d     = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      sel_q       <= 3'd0;
      out_valid_q <= 8'h00;
      out_data_q  <= '0;
      sent_q      <= 1'b0;
      drop_cnt_q  <= 8'd0;
      rr_ptr_q    <= 3'd0;
      wait_q      <= 8'd0;
      mode_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sent_q      <= sent_d;
      drop_cnt_q  <= drop_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      wait_q      <= wait_d;
      mode_q      <= mode_d;
    end
  end

  assign sel       = sel_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sent      = sent_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_demux_dispatcher.sv
// Directed bench for demux_dispatcher with a delivery scoreboard.
module tb_demux_dispatcher;

  typedef struct packed {
    logic [2:0] ch;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode;
  logic [7:0] chan_enable;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_dest;
  logic [2:0] sel;
  logic [7:0] out_valid;
  logic [7:0] out_data;
  logic [7:0] out_ready;
  logic       sent;
  logic [7:0] drop_cnt;

  int   tests = 0;
  int   fails = 0;
  int   sent_cnt = 0;
  logic mon_en = 1'b0;
  logic exp_sent = 1'b0;
  exp_t sb[$];

  demux_dispatcher #(
    .DATA_WIDTH(8),
    .TIMEOUT   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .chan_enable(chan_enable),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_dest    (in_dest),
    .sel        (sel),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .sent       (sent),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Negedge checks: sent pulse, one-hot invariant, scoreboard pop on handshake.
  task automatic monitor();
    exp_t e;
    if (mon_en) begin
      chk("sent_pulse", 32'(sent), 32'(exp_sent));
      if (sent === 1'b1) sent_cnt++;
      chk("onehot", 32'(out_valid == 8'h00 || out_valid == (8'h01 << sel)), 32'd1);
      exp_sent = 1'b0;
      if ((out_valid & out_ready) != 8'h00) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("deliver_ch", 32'(sel), 32'(e.ch));
          chk("deliver_data", 32'(out_data), 32'(e.data));
        end
        exp_sent = !rst;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] ch, input logic [7:0] data);
    exp_t e;
    e.ch   = ch;
    e.data = data;
    sb.push_back(e);
  endtask

  // Present a word, wait (bounded) for in_ready, then check out_valid after acceptance.
  task automatic send_word(input logic m, input logic [2:0] dest, input logic [7:0] data,
                           input logic [7:0] exp_ov);
    int n;
    n        = 0;
    mode     = m;
    in_dest  = dest;
    in_data  = data;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("accept_out_valid", 32'(out_valid), 32'(exp_ov));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((out_valid != 8'h00 || sb.size() != 0) && n < 100) begin
      tick();
      n++;
    end
    chk("drain", 32'(out_valid == 8'h00 && sb.size() == 0), 32'd1);
  endtask

  initial begin
    rst         = 1'b1;
    mode        = 1'b0;
    chan_enable = 8'hFF;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    in_dest     = 3'd0;
    out_ready   = 8'hFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'h00);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_sent", 32'(sent), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h00);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    mon_en = 1'b1;

    // Round-robin sweep over all channels, then wrap to channel 0.
    for (int i = 0; i < 8; i++) begin
      push(3'(i), 8'h10 + 8'(i));
      send_word(1'b0, 3'd0, 8'h10 + 8'(i), 8'h01 << i);
      wait_idle();
    end
    push(3'd0, 8'h18);
    send_word(1'b0, 3'd0, 8'h18, 8'h01);
    wait_idle();
    tick();
    chk("rr_sent_count", 32'(sent_cnt), 32'd9);

    // Round-robin skip over a sparse mask: 2, 5, 7, 2.
    chan_enable = 8'b1010_0100;
    push(3'd2, 8'h20); send_word(1'b0, 3'd0, 8'h20, 8'h04); wait_idle();
    push(3'd5, 8'h21); send_word(1'b0, 3'd0, 8'h21, 8'h20); wait_idle();
    push(3'd7, 8'h22); send_word(1'b0, 3'd0, 8'h22, 8'h80); wait_idle();
    push(3'd2, 8'h23); send_word(1'b0, 3'd0, 8'h23, 8'h04); wait_idle();

    // Addressed: disabled destination is dropped, enabled one is delivered.
    chan_enable = 8'hF0;
    send_word(1'b1, 3'd3, 8'h33, 8'h00);
    chk("addr_drop_cnt", 32'(drop_cnt), 32'd1);
    push(3'd6, 8'hA5);
    send_word(1'b1, 3'd6, 8'hA5, 8'h40);
    chk("addr_out_data", 32'(out_data), 32'hA5);
    wait_idle();

    // Timeout retarget 0 -> 1 after 4 presented cycles (rr_ptr is 3 here).
    chan_enable = 8'h03;
    out_ready   = 8'h02;
    push(3'd1, 8'h5A);
    send_word(1'b0, 3'd0, 8'h5A, 8'h01);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_still_ch0", 32'(out_valid), 32'h01);
    end
    tick();
    chk("to_retarget_ch1", 32'(out_valid), 32'h02);
    wait_idle();
    chk("to_drop_cnt", 32'(drop_cnt), 32'd1);

    // Round-robin with a single enabled channel keeps waiting past the timeout.
    chan_enable = 8'h01;
    out_ready   = 8'h00;
    send_word(1'b0, 3'd0, 8'h66, 8'h01);
    for (int i = 0; i < 6; i++) tick();
    chk("wait_keep_valid", 32'(out_valid), 32'h01);
    chk("wait_keep_drop", 32'(drop_cnt), 32'd1);
    push(3'd0, 8'h66);
    out_ready = 8'h01;
    wait_idle();

    // Collision: ready rises in the timeout cycle, delivery wins.
    chan_enable = 8'hFF;
    out_ready   = 8'h00;
    push(3'd4, 8'h44);
    send_word(1'b1, 3'd4, 8'h44, 8'h10);
    for (int i = 0; i < 3; i++) tick();
    out_ready = 8'h10;
    tick();
    chk("coll_out_valid", 32'(out_valid), 32'h00);
    chk("coll_sent", 32'(sent), 32'd1);
    chk("coll_drop_cnt", 32'(drop_cnt), 32'd1);
    out_ready = 8'h00;
    tick();

    // Addressed word dropped when its channel is disabled mid-delivery.
    send_word(1'b1, 3'd5, 8'h55, 8'h20);
    chan_enable = 8'hDF;
    tick();
    chk("dis_out_valid", 32'(out_valid), 32'h00);
    chk("dis_drop_cnt", 32'(drop_cnt), 32'd2);
    chk("dis_sent", 32'(sent), 32'd0);
    chan_enable = 8'hFF;

    // Reset mid-delivery discards the word without counting a drop.
    send_word(1'b1, 3'd2, 8'h22, 8'h04);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_out_valid", 32'(out_valid), 32'h00);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("mid_rst_sel", 32'(sel), 32'd0);

    // Saturation of the drop counter.
    chan_enable = 8'h00;
    for (int i = 0; i < 260; i++) begin
      send_word(1'b1, 3'(i), 8'(i), 8'h00);
      if (i == 253) chk("sat_254", 32'(drop_cnt), 32'd254);
      if (i == 254) chk("sat_255", 32'(drop_cnt), 32'd255);
    end
    chk("sat_hold", 32'(drop_cnt), 32'd255);
    tick();
    chk("sb_empty_end", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/demux_dispatcher.md
Name: demux_dispatcher

Overview:
- Sequencing controller for the 3-to-8 demultiplexer: accepts one valid/ready input stream and steers each word to one of 8 consumer channels.
- Generates the demux select plus per-channel valid/ready handshakes.
- Channel choice comes from one of two modes: round-robin over enabled channels, or addressed by a per-word destination.
- A stalled consumer is bypassed after a programmable timeout.

Parameters:
- DATA_WIDTH, 8, width of in_data/out_data.
- TIMEOUT, 15, DELIVER wait cycles before retarget/drop; legal range 1..255.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = round-robin, 1 = addressed; sampled only at word acceptance.
- chan_enable  input  8  per-channel enable mask.
- in_valid  input  1  input word present.
- in_ready  output  1  dispatcher accepts word this cycle.
- in_data  input  DATA_WIDTH  input word.
- in_dest  input  3  destination channel (used in addressed mode).
- sel  output  3  demultiplexer select, registered.
- out_valid  output  8  one-hot valid toward channel sel.
- out_data  output  DATA_WIDTH  held word, shared by all channels.
- out_ready  input  8  per-channel ready.
- sent  output  1  one-cycle pulse on completed delivery.
- drop_cnt  output  8  saturating count of dropped words.

Behaviour:
- Reset (rst=1 at an edge), effective next cycle:
  - state=IDLE, sel=0, out_valid=0, out_data=0, sent=0, drop_cnt=0, rr_ptr=0, wait counter=0.
  - Reset mid-DELIVER discards the held word without counting a drop.
- States:
  - IDLE: no word held.
  - DELIVER: word held in a register and presented on channel sel.
- IDLE, in_ready:
  - RR mode: in_ready=1 iff |chan_enable.
  - Addressed mode: in_ready=1 always.
  - in_ready is combinational from state/mode/chan_enable only, never from in_valid.
- IDLE, acceptance (in_valid && in_ready):
  - out_data<=in_data, mode latched, wait counter cleared.
  - RR target: first enabled channel scanning rr_ptr, rr_ptr+1, ... mod 8.
  - Addressed target: in_dest.
  - Addressed with chan_enable[in_dest]=0: word dropped, drop_cnt+1, stay IDLE.
  - Otherwise: sel<=target, out_valid<=one-hot(target), state<=DELIVER.
- Latency: accept at edge N, out_valid visible after edge N; minimum 2 cycles per word (no back-to-back acceptance).
- DELIVER, completion:
  - Handshake completes when out_ready[sel]=1 (out_valid[sel] is 1 in this state).
  - At that edge: out_valid<=0, sent<=1 for one cycle, state<=IDLE.
  - RR only: rr_ptr<=(sel+1) mod 8, 3-bit wrap, so 7 wraps to 0.
- in_ready=0 throughout DELIVER.
- DELIVER, no handshake: wait counter increments each cycle.
- Retarget/drop: triggered when wait counter reaches TIMEOUT, or when chan_enable[sel] drops to 0.
  - RR with another enabled channel: retarget to next enabled after sel (sel excluded); out_valid follows; counter cleared.
  - RR with no other enabled channel but sel still enabled: keep waiting, counter cleared.
  - RR with no channel enabled: drop.
  - Addressed: drop.
  - Drop: drop_cnt+1 saturating at 255, out_valid<=0, state<=IDLE, no sent.
- Simultaneous events:
  - out_ready[sel]=1 in the same cycle as timeout or disable: delivery wins, no drop.
  - out_ready on channels other than sel: ignored.
- out_valid is always zero or one-hot and equals one-hot(sel) when nonzero.
- out_data is stable while out_valid≠0.

Test Plan:
- RR sweep: enable=8'hFF, mode=0, 8 words 0x10..0x17, all out_ready=1 -> sel 0..7 in order, out_valid 01,02,...,80, 8 sent pulses, rr_ptr wraps to 0, 9th word goes to channel 0.
- RR skip: enable=8'b1010_0100, 4 words -> sel sequence 2,5,7,2.
- Addressed drop: mode=1, enable=8'hF0, in_dest=3 -> no out_valid, drop_cnt=1; in_dest=6 data 0xA5 -> out_valid=8'h40, out_data=0xA5.
- Timeout retarget: TIMEOUT=4, enable=8'h03, out_ready[0]=0, out_ready[1]=1 -> after 4 wait cycles sel switches 0->1, delivery on channel 1, drop_cnt unchanged.
- Collision: addressed, out_ready[sel] rises in the timeout cycle -> sent=1, drop_cnt unchanged; mid-DELIVER disable of sel in addressed mode -> drop_cnt+1.
- Reset mid-DELIVER and saturation: rst during DELIVER -> next cycle out_valid=0, in_ready=1, drop_cnt=0; 260 addressed drops -> drop_cnt holds 255.
